// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a small return-address stack.
// Supports INC/JMP/BRC/CALL/RET/HOLD, and flags stack overflow and underflow with one-cycle pulses.
module pc_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               en,
    input  logic [2:0]                         op,
    input  logic [ADDR_W-1:0]                  target,
    input  logic                               cond,
    output logic [ADDR_W-1:0]                  pc_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               ovf,
    output logic                               unf
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    // Storage is rounded up to a power of two so the pointer width matches the array exactly.
    localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BRC  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HOLD = 3'b101;

    logic [ADDR_W-1:0]  stack_mem [0:(1<<PTR_W)-1];
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  pc_next;
    logic [DEPTH_W-1:0] depth_next;
    logic [PTR_W-1:0]   push_idx;
    logic [PTR_W-1:0]   pop_idx;
    logic               push;
    logic               ovf_next;
    logic               unf_next;

    assign stack_full  = (depth == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth == '0);
    assign pc_inc      = pc_out + ADDR_W'(1);
    assign push_idx    = PTR_W'(depth);
    assign pop_idx     = PTR_W'(depth - DEPTH_W'(1));

    always_comb begin
        pc_next    = pc_out;
        depth_next = depth;
        push       = 1'b0;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (en) begin
            case (op)
                OP_JMP:  pc_next = target;
                // Same-width add is the sign-extended offset taken modulo 2^ADDR_W.
                OP_BRC:  pc_next = cond ? (pc_out + target) : pc_inc;
                OP_CALL: begin
                    if (stack_full) begin
                        pc_next  = pc_inc;
                        ovf_next = 1'b1;
                    end else begin
                        pc_next    = target;
                        push       = 1'b1;
                        depth_next = depth + DEPTH_W'(1);
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        pc_next  = pc_inc;
                        unf_next = 1'b1;
                    end else begin
                        pc_next    = stack_mem[pop_idx];
                        depth_next = depth - DEPTH_W'(1);
                    end
                end
                OP_HOLD: pc_next = pc_out;
                default: pc_next = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_out <= ADDR_W'(RESET_PC);
            depth  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            pc_out <= pc_next;
            depth  <= depth_next;
            ovf    <= ovf_next;
            unf    <= unf_next;
        end
    end

    // Entries above depth are dead, so the storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (ADDR_W=8, STACK_DEPTH=4, RESET_PC=0).
// A reference model pushes expectations per step; each test pops and compares them, along with table constants.
module tb_pc_sequencer;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [2:0] op;
    logic [7:0] target;
    logic       cond;
    logic [7:0] pc_out;
    logic [2:0] depth;
    logic       stack_full;
    logic       stack_empty;
    logic       ovf;
    logic       unf;

    pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_PC(0)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .op(op), .target(target), .cond(cond),
        .pc_out(pc_out), .depth(depth), .stack_full(stack_full), .stack_empty(stack_empty),
        .ovf(ovf), .unf(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] op;
        logic [7:0] tgt;
        logic       c;
    } stim_t;

    typedef struct {
        logic [7:0] pc;
        logic [2:0] depth;
        logic       ovf;
        logic       unf;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb [$];
    exp_t       exp_v;
    logic [7:0] m_pc;
    logic [7:0] m_stack [$];

    // Drive one op at the falling edge, push the model's expectation, sample 1 ns after the rising edge.
    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        en     = s.en;
        op     = s.op;
        target = s.tgt;
        cond   = s.c;
        e.ovf  = 1'b0;
        e.unf  = 1'b0;
        if (s.en) begin
            case (s.op)
                3'd1: m_pc = s.tgt;
                3'd2: m_pc = s.c ? m_pc + s.tgt : m_pc + 8'd1;
                3'd3: begin
                    if (m_stack.size() == 4) begin
                        m_pc  = m_pc + 8'd1;
                        e.ovf = 1'b1;
                    end else begin
                        m_stack.push_back(m_pc + 8'd1);
                        m_pc = s.tgt;
                    end
                end
                3'd4: begin
                    if (m_stack.size() == 0) begin
                        m_pc  = m_pc + 8'd1;
                        e.unf = 1'b1;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end
                3'd5: m_pc = m_pc;
                default: m_pc = m_pc + 8'd1;
            endcase
        end
        e.pc    = m_pc;
        e.depth = 3'(m_stack.size());
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en      = 1'b0;
        reset_n = 1'b0;
        #2;
        m_pc = 8'h00;
        m_stack.delete();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en      = 1'b0;
        op      = 3'd0;
        target  = 8'h00;
        cond    = 1'b0;
        m_pc    = 8'h00;
        m_stack.delete();
        #3;
        checks++;
        if (pc_out !== 8'h00 || depth !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0 ||
            ovf !== 1'b0 || unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h depth=%0d empty=%b full=%b ovf=%b unf=%b required pc=00 depth=0 empty=1 full=0 ovf=0 unf=0",
                     pc_out, depth, stack_empty, stack_full, ovf, unf);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 261; i++) begin
            step('{1'b1, 3'd0, 8'h00, 1'b0});
            exp_v = sb.pop_front();
            checks++;
            if (pc_out !== exp_v.pc || depth !== exp_v.depth || ovf !== 1'b0 || unf !== 1'b0) begin
                errors++;
                $display("FAIL wrap_inc[%0d] pc=%h depth=%0d required pc=%h depth=%0d", i, pc_out, depth, exp_v.pc, exp_v.depth);
            end
            if (i == 255) begin
                checks++;
                if (pc_out !== 8'h00) begin
                    errors++;
                    $display("FAIL wrap_to_zero pc=%h required 00", pc_out);
                end
            end
        end
        // pc is now 0x05; reset lands between edges and must act at once.
        @(negedge clk);
        en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pc_out !== 8'h00 || depth !== 3'd0) begin
            errors++;
            $display("FAIL async_reset pc=%h depth=%0d required pc=00 depth=0", pc_out, depth);
        end
        m_pc = 8'h00;
        m_stack.delete();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_branch();
        stim_t s [9] = '{'{1'b1, 3'd1, 8'h10, 1'b0}, '{1'b1, 3'd2, 8'hFC, 1'b1}, '{1'b1, 3'd2, 8'hFC, 1'b0},
                         '{1'b1, 3'd1, 8'h02, 1'b0}, '{1'b1, 3'd2, 8'hFC, 1'b1}, '{1'b1, 3'd1, 8'h80, 1'b0},
                         '{1'b1, 3'd2, 8'h05, 1'b1}, '{1'b1, 3'd1, 8'hFE, 1'b0}, '{1'b1, 3'd2, 8'h04, 1'b1}};
        logic [7:0] want [9] = '{8'h10, 8'h0C, 8'h0D, 8'h02, 8'hFE, 8'h80, 8'h85, 8'hFE, 8'h02};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(s[i]);
            exp_v = sb.pop_front();
            checks++;
            if (pc_out !== exp_v.pc || pc_out !== want[i] || depth !== exp_v.depth || ovf !== exp_v.ovf || unf !== exp_v.unf) begin
                errors++;
                $display("FAIL branch[%0d] pc=%h depth=%0d ovf=%b unf=%b required pc=%h depth=%0d ovf=%b unf=%b",
                         i, pc_out, depth, ovf, unf, want[i], exp_v.depth, exp_v.ovf, exp_v.unf);
            end
        end
    endtask

    task automatic test_nesting();
        stim_t s [5] = '{'{1'b1, 3'd1, 8'h20, 1'b0}, '{1'b1, 3'd3, 8'h40, 1'b0}, '{1'b1, 3'd3, 8'h60, 1'b0},
                         '{1'b1, 3'd4, 8'h00, 1'b0}, '{1'b1, 3'd4, 8'h00, 1'b0}};
        exp_t want [5] = '{'{8'h20, 3'd0, 1'b0, 1'b0}, '{8'h40, 3'd1, 1'b0, 1'b0}, '{8'h60, 3'd2, 1'b0, 1'b0},
                           '{8'h41, 3'd1, 1'b0, 1'b0}, '{8'h21, 3'd0, 1'b0, 1'b0}};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(s[i]);
            exp_v = sb.pop_front();
            checks++;
            if (pc_out !== exp_v.pc || pc_out !== want[i].pc || depth !== want[i].depth || depth !== exp_v.depth ||
                stack_empty !== (want[i].depth == 3'd0) || ovf !== 1'b0 || unf !== 1'b0) begin
                errors++;
                $display("FAIL nesting[%0d] pc=%h depth=%0d empty=%b required pc=%h depth=%0d empty=%b",
                         i, pc_out, depth, stack_empty, want[i].pc, want[i].depth, want[i].depth == 3'd0);
            end
        end
    endtask

    task automatic test_overflow();
        stim_t s [10] = '{'{1'b1, 3'd1, 8'h20, 1'b0}, '{1'b1, 3'd3, 8'h30, 1'b0}, '{1'b1, 3'd3, 8'h31, 1'b0},
                          '{1'b1, 3'd3, 8'h32, 1'b0}, '{1'b1, 3'd3, 8'h33, 1'b0}, '{1'b1, 3'd3, 8'h70, 1'b0},
                          '{1'b1, 3'd4, 8'h00, 1'b0}, '{1'b1, 3'd4, 8'h00, 1'b0}, '{1'b1, 3'd4, 8'h00, 1'b0},
                          '{1'b1, 3'd4, 8'h00, 1'b0}};
        exp_t want [10] = '{'{8'h20, 3'd0, 1'b0, 1'b0}, '{8'h30, 3'd1, 1'b0, 1'b0}, '{8'h31, 3'd2, 1'b0, 1'b0},
                            '{8'h32, 3'd3, 1'b0, 1'b0}, '{8'h33, 3'd4, 1'b0, 1'b0}, '{8'h34, 3'd4, 1'b1, 1'b0},
                            '{8'h33, 3'd3, 1'b0, 1'b0}, '{8'h32, 3'd2, 1'b0, 1'b0}, '{8'h31, 3'd1, 1'b0, 1'b0},
                            '{8'h21, 3'd0, 1'b0, 1'b0}};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(s[i]);
            exp_v = sb.pop_front();
            checks++;
            if (pc_out !== exp_v.pc || pc_out !== want[i].pc || depth !== want[i].depth || depth !== exp_v.depth ||
                ovf !== want[i].ovf || ovf !== exp_v.ovf || unf !== 1'b0 || stack_full !== (want[i].depth == 3'd4)) begin
                errors++;
                $display("FAIL overflow[%0d] pc=%h depth=%0d ovf=%b full=%b required pc=%h depth=%0d ovf=%b full=%b",
                         i, pc_out, depth, ovf, stack_full, want[i].pc, want[i].depth, want[i].ovf, want[i].depth == 3'd4);
            end
        end
    endtask

    task automatic test_underflow();
        stim_t s [6] = '{'{1'b1, 3'd1, 8'h05, 1'b0}, '{1'b1, 3'd4, 8'h00, 1'b0}, '{1'b1, 3'd5, 8'h00, 1'b0},
                         '{1'b1, 3'd4, 8'h00, 1'b0}, '{1'b1, 3'd4, 8'h00, 1'b0}, '{1'b1, 3'd0, 8'h00, 1'b0}};
        exp_t want [6] = '{'{8'h05, 3'd0, 1'b0, 1'b0}, '{8'h06, 3'd0, 1'b0, 1'b1}, '{8'h06, 3'd0, 1'b0, 1'b0},
                           '{8'h07, 3'd0, 1'b0, 1'b1}, '{8'h08, 3'd0, 1'b0, 1'b1}, '{8'h09, 3'd0, 1'b0, 1'b0}};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(s[i]);
            exp_v = sb.pop_front();
            checks++;
            if (pc_out !== exp_v.pc || pc_out !== want[i].pc || depth !== 3'd0 || depth !== exp_v.depth ||
                unf !== want[i].unf || unf !== exp_v.unf || ovf !== 1'b0) begin
                errors++;
                $display("FAIL underflow[%0d] pc=%h depth=%0d unf=%b required pc=%h depth=0 unf=%b",
                         i, pc_out, depth, unf, want[i].pc, want[i].unf);
            end
        end
    endtask

    task automatic test_stall();
        stim_t s [10] = '{'{1'b1, 3'd1, 8'h10, 1'b0}, '{1'b1, 3'd3, 8'h50, 1'b0}, '{1'b0, 3'd3, 8'h70, 1'b0},
                          '{1'b0, 3'd4, 8'h00, 1'b0}, '{1'b0, 3'd1, 8'h99, 1'b0}, '{1'b1, 3'd5, 8'h00, 1'b0},
                          '{1'b1, 3'd6, 8'h00, 1'b0}, '{1'b1, 3'd7, 8'h00, 1'b0}, '{1'b1, 3'd4, 8'h00, 1'b0},
                          '{1'b0, 3'd4, 8'h00, 1'b0}};
        exp_t want [10] = '{'{8'h10, 3'd0, 1'b0, 1'b0}, '{8'h50, 3'd1, 1'b0, 1'b0}, '{8'h50, 3'd1, 1'b0, 1'b0},
                            '{8'h50, 3'd1, 1'b0, 1'b0}, '{8'h50, 3'd1, 1'b0, 1'b0}, '{8'h50, 3'd1, 1'b0, 1'b0},
                            '{8'h51, 3'd1, 1'b0, 1'b0}, '{8'h52, 3'd1, 1'b0, 1'b0}, '{8'h11, 3'd0, 1'b0, 1'b0},
                            '{8'h11, 3'd0, 1'b0, 1'b0}};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(s[i]);
            exp_v = sb.pop_front();
            checks++;
            if (pc_out !== exp_v.pc || pc_out !== want[i].pc || depth !== want[i].depth || depth !== exp_v.depth ||
                ovf !== 1'b0 || unf !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] pc=%h depth=%0d ovf=%b unf=%b required pc=%h depth=%0d ovf=0 unf=0",
                         i, pc_out, depth, ovf, unf, want[i].pc, want[i].depth);
            end
        end
    endtask

    task automatic test_reset_stack();
        stim_t s [4] = '{'{1'b1, 3'd1, 8'h10, 1'b0}, '{1'b1, 3'd3, 8'h40, 1'b0}, '{1'b1, 3'd3, 8'h50, 1'b0},
                         '{1'b1, 3'd4, 8'h00, 1'b0}};
        exp_t want [4] = '{'{8'h10, 3'd0, 1'b0, 1'b0}, '{8'h40, 3'd1, 1'b0, 1'b0}, '{8'h50, 3'd2, 1'b0, 1'b0},
                           '{8'h01, 3'd0, 1'b0, 1'b1}};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) do_reset();
            step(s[i]);
            exp_v = sb.pop_front();
            checks++;
            if (pc_out !== exp_v.pc || pc_out !== want[i].pc || depth !== want[i].depth || depth !== exp_v.depth ||
                unf !== want[i].unf || ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_stack[%0d] pc=%h depth=%0d unf=%b required pc=%h depth=%0d unf=%b",
                         i, pc_out, depth, unf, want[i].pc, want[i].depth, want[i].unf);
            end
        end
    endtask

    task automatic test_random();
        stim_t r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r.en  = ($urandom_range(0, 7) != 0);
            r.op  = 3'($urandom_range(0, 7));
            r.tgt = 8'($urandom_range(0, 255));
            r.c   = 1'($urandom_range(0, 1));
            step(r);
            exp_v = sb.pop_front();
            checks++;
            if (pc_out !== exp_v.pc || depth !== exp_v.depth || ovf !== exp_v.ovf || unf !== exp_v.unf ||
                stack_full !== (exp_v.depth == 3'd4) || stack_empty !== (exp_v.depth == 3'd0)) begin
                errors++;
                $display("FAIL random[%0d] op=%0d en=%b pc=%h depth=%0d ovf=%b unf=%b required pc=%h depth=%0d ovf=%b unf=%b",
                         i, r.op, r.en, pc_out, depth, ovf, unf, exp_v.pc, exp_v.depth, exp_v.ovf, exp_v.unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_branch();
        test_nesting();
        test_overflow();
        test_underflow();
        test_stall();
        test_reset_stack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
